// File: rtl/regfile_ctrl.sv
// Requester-side controller for a single-port regfile (async read, sync write, active-low we_).
// Accepts READ/WRITE/ADD/FILL commands over valid-ready and returns read data over valid-ready.
module regfile_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DATA_D = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_FILL = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_D - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_d_in_q, rf_d_in_d;
  logic              rf_we_n_q, rf_we_n_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              cmd_in_range;

  assign cmd_in_range = ({1'b0, cmd_addr} < (ADDR_W+1)'(DATA_D));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    rf_addr_d   = rf_addr_q;
    rf_d_in_d   = rf_d_in_q;
    rf_we_n_d   = 1'b1;
    fill_cnt_d  = fill_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          err_d  = ~cmd_in_range;
          case (cmd_op)
            OP_WRITE: begin
              state_d   = S_WR;
              rf_addr_d = cmd_addr;
              rf_d_in_d = cmd_data;
              rf_we_n_d = ~cmd_in_range;
            end
            OP_FILL: begin
              state_d    = S_FILL;
              fill_cnt_d = '0;
              rf_addr_d  = '0;
              rf_d_in_d  = cmd_data;
              rf_we_n_d  = 1'b0;
            end
            default: begin
              state_d   = S_RD;
              rf_addr_d = cmd_addr;
            end
          endcase
        end
      end
      S_RD: begin
        // Out-of-range reads report zero rather than whatever the regfile decodes.
        resp_data_d = err_q ? '0 : rf_d_out;
        resp_err_d  = err_q;
        if (op_q == OP_ADD) begin
          state_d   = S_WR;
          rf_d_in_d = rf_d_out + data_q;
          rf_we_n_d = err_q;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WR:   state_d = (op_q == OP_ADD) ? S_RESP : S_IDLE;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      S_FILL: begin
        if (fill_cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          rf_addr_d  = fill_cnt_q + 1'b1;
          rf_we_n_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      data_q      <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      rf_addr_q   <= '0;
      rf_d_in_q   <= '0;
      rf_we_n_q   <= 1'b1;
      fill_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      rf_addr_q   <= rf_addr_d;
      rf_d_in_q   <= rf_d_in_d;
      rf_we_n_q   <= rf_we_n_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign rf_addr    = rf_addr_q;
  assign rf_d_in    = rf_d_in_q;
  assign rf_we_     = rf_we_n_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: two instances (depth 16 and depth 12), each with its own regfile model,
// an array-based reference model, and queue scoreboards for responses and regfile writes.
module tb_regfile_ctrl;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rf_load;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [1:0]  cmd_op    [2];
  logic [3:0]  cmd_addr  [2];
  logic [31:0] cmd_data  [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_data [2];
  logic        resp_err  [2];
  logic        busy      [2];
  logic [3:0]  rf_addr   [2];
  logic [31:0] rf_d_in   [2];
  logic        rf_we_n   [2];
  logic [31:0] rf_d_out  [2];

  logic [31:0] rf    [2][16];
  logic [31:0] model [2][16];
  resp_t       exp_resp[2][$];
  wr_t         exp_wr  [2][$];
  int          wr_count[2];
  logic        rr_random[2];
  logic        rr_manual[2];
  logic        prev_stall[2];
  logic [32:0] held[2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_ctrl #(.ADDR_W(4), .DATA_W(32), .DATA_D(16)) u_dut0 (
    .clk(clk), .reset_(reset_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
    .resp_err(resp_err[0]), .busy(busy[0]),
    .rf_addr(rf_addr[0]), .rf_d_in(rf_d_in[0]), .rf_we_(rf_we_n[0]), .rf_d_out(rf_d_out[0])
  );

  regfile_ctrl #(.ADDR_W(4), .DATA_W(32), .DATA_D(12)) u_dut1 (
    .clk(clk), .reset_(reset_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
    .resp_err(resp_err[1]), .busy(busy[1]),
    .rf_addr(rf_addr[1]), .rf_d_in(rf_d_in[1]), .rf_we_(rf_we_n[1]), .rf_d_out(rf_d_out[1])
  );

  function automatic int depth(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic logic [31:0] init_val(input int k, input int i);
    return 32'(k * 32'h1357_0000 + i * 32'h0101_0101 + 32'h5A00_0000);
  endfunction

  // Regfile models: asynchronous read, write on rising edge while we_ is low.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rf_load) begin
        for (int i = 0; i < 16; i++) rf[k][i] <= init_val(k, i);
      end else if (rf_we_n[k] == 1'b0) begin
        rf[k][rf_addr[k]] <= rf_d_in[k];
      end
    end
  end

  assign rf_d_out[0] = rf[0][rf_addr[0]];
  assign rf_d_out[1] = rf[1][rf_addr[1]];

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int k, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s inst=%0d got=%h expected=nothing t=%0t", name, k, act, $time);
  endtask

  // Response-ready driver: random or a held manual level, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++)
        resp_ready[k] = rr_random[k] ? ($urandom_range(0, 3) != 0) : rr_manual[k];
    end
  end

  // Monitor: pops the scoreboards whenever the DUT writes the regfile or completes a response.
  initial begin : monitor
    wr_t   w;
    resp_t r;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) begin
          prev_stall[k] = 1'b0;
          continue;
        end
        if (rf_we_n[k] == 1'b0) begin
          wr_count[k]++;
          if (exp_wr[k].size() == 0) begin
            fail_now("unexpected_write", k, 64'({rf_addr[k], rf_d_in[k]}));
          end else begin
            w = exp_wr[k].pop_front();
            check("write_addr", k, 64'(rf_addr[k]), 64'(w.addr));
            check("write_data", k, 64'(rf_d_in[k]), 64'(w.data));
          end
        end
        if (prev_stall[k]) begin
          check("resp_hold_valid", k, 64'(resp_valid[k]), 64'd1);
          check("resp_hold_data", k, 64'({resp_data[k], resp_err[k]}), 64'(held[k]));
        end
        if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) begin
          if (exp_resp[k].size() == 0) begin
            fail_now("unexpected_resp", k, 64'({resp_data[k], resp_err[k]}));
          end else begin
            r = exp_resp[k].pop_front();
            check("resp_data", k, 64'(resp_data[k]), 64'(r.data));
            check("resp_err", k, 64'(resp_err[k]), 64'(r.err));
          end
        end
        prev_stall[k] = (resp_valid[k] === 1'b1) && (resp_ready[k] !== 1'b1);
        held[k]       = {resp_data[k], resp_err[k]};
      end
    end
  end

  task automatic send(input int k, input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data);
    int n;
    @(posedge clk);
    #1;
    cmd_valid[k] = 1'b1;
    cmd_op[k]    = op;
    cmd_addr[k]  = addr;
    cmd_data[k]  = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready[k] === 1'b1) break;
      n++;
      if (n > 200) begin
        fail_now("cmd_accept_timeout", k, 64'(op));
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid[k] = 1'b0;
    cmd_op[k]    = 2'($urandom);
    cmd_addr[k]  = 4'($urandom);
    cmd_data[k]  = $urandom;
  endtask

  // Reference model: applies the command to the entry array and queues what the DUT must produce.
  task automatic issue(input int k, input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data);
    logic        in_r;
    logic [31:0] old;
    resp_t       r;
    wr_t         w;
    in_r = (int'(addr) < depth(k));
    old  = in_r ? model[k][addr] : 32'h0;
    case (op)
      OP_READ: begin
        r.data = old; r.err = ~in_r;
        exp_resp[k].push_back(r);
      end
      OP_WRITE: begin
        if (in_r) begin
          model[k][addr] = data;
          w.addr = addr; w.data = data;
          exp_wr[k].push_back(w);
        end
      end
      OP_ADD: begin
        if (in_r) begin
          model[k][addr] = old + data;
          w.addr = addr; w.data = old + data;
          exp_wr[k].push_back(w);
        end
        r.data = old; r.err = ~in_r;
        exp_resp[k].push_back(r);
      end
      default: begin
        for (int i = 0; i < depth(k); i++) begin
          model[k][i] = data;
          w.addr = 4'(i); w.data = data;
          exp_wr[k].push_back(w);
        end
      end
    endcase
    send(k, op, addr, data);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (exp_resp[k].size() != 0 || exp_wr[k].size() != 0) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 1000) begin
        fail_now("drain_timeout", k, 64'(exp_resp[k].size() + exp_wr[k].size()));
        break;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    int base;
    int cnt;
    int n;
    logic [31:0] stall_data;
    logic [3:0]  ra;
    int          sel;

    reset_n = 1'b0;
    rf_load = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_op[k]    = OP_READ;
      cmd_addr[k]  = 4'h0;
      cmd_data[k]  = 32'h0;
      rr_random[k] = 1'b0;
      rr_manual[k] = 1'b1;
      wr_count[k]  = 0;
      prev_stall[k] = 1'b0;
      for (int i = 0; i < 16; i++) model[k][i] = init_val(k, i);
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_cmd_ready", k, 64'(cmd_ready[k]), 64'd1);
      check("rst_resp_valid", k, 64'(resp_valid[k]), 64'd0);
      check("rst_resp_data", k, 64'(resp_data[k]), 64'd0);
      check("rst_resp_err", k, 64'(resp_err[k]), 64'd0);
      check("rst_busy", k, 64'(busy[k]), 64'd0);
      check("rst_rf_we", k, 64'(rf_we_n[k]), 64'd1);
      check("rst_rf_addr", k, 64'(rf_addr[k]), 64'd0);
      check("rst_rf_d_in", k, 64'(rf_d_in[k]), 64'd0);
    end
    rf_load = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;

    // WRITE then READ: one-cycle write pulse, 1-per-2 write rate, READ response two cycles after accept.
    issue(0, OP_WRITE, 4'd3, 32'hDEADBEEF);
    @(negedge clk);
    check("write_pulse_low", 0, 64'(rf_we_n[0]), 64'd0);
    @(negedge clk);
    check("write_pulse_end", 0, 64'(rf_we_n[0]), 64'd1);
    check("write_rate_ready", 0, 64'(cmd_ready[0]), 64'd1);
    issue(0, OP_READ, 4'd3, $urandom);
    @(negedge clk);
    check("read_lat_n1", 0, 64'(resp_valid[0]), 64'd0);
    @(negedge clk);
    check("read_lat_n2_valid", 0, 64'(resp_valid[0]), 64'd1);
    check("read_lat_n2_data", 0, 64'(resp_data[0]), 64'hDEADBEEF);
    check("read_lat_n2_err", 0, 64'(resp_err[0]), 64'd0);
    @(negedge clk);
    check("read_rate_ready", 0, 64'(cmd_ready[0]), 64'd1);

    // ADD wraps modulo 2**32 and returns the pre-add value.
    issue(0, OP_WRITE, 4'd5, 32'hFFFFFFFF);
    issue(0, OP_ADD, 4'd5, 32'd2);
    issue(0, OP_READ, 4'd5, 32'h0);
    drain(0);
    check("add_wrap_entry", 0, 64'(rf[0][5]), 64'h1);

    // FILL: busy for exactly DATA_D cycles with one write per cycle.
    base = wr_count[0];
    issue(0, OP_FILL, 4'($urandom), 32'hA5A5A5A5);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (busy[0] !== 1'b1) break;
      cnt++;
    end
    check("fill_busy_cycles", 0, 64'(cnt), 64'd16);
    check("fill_write_pulses", 0, 64'(wr_count[0] - base), 64'd16);
    for (int i = 0; i < 16; i++) issue(0, OP_READ, 4'(i), $urandom);
    drain(0);

    // Response back-pressure: five stalled cycles, then release.
    rr_manual[0] = 1'b0;
    issue(0, OP_READ, 4'd7, 32'h0);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stall_resp_seen", 0, 64'(resp_valid[0]), 64'd1);
    check("stall_resp_data", 0, 64'(resp_data[0]), 64'hA5A5A5A5);
    stall_data = resp_data[0];
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 0, 64'(resp_valid[0]), 64'd1);
      check("stall_data", 0, 64'(resp_data[0]), 64'(stall_data));
      check("stall_cmd_ready", 0, 64'(cmd_ready[0]), 64'd0);
    end
    rr_manual[0] = 1'b1;
    @(negedge clk);
    check("release_still_valid", 0, 64'(resp_valid[0]), 64'd1);
    @(negedge clk);
    check("release_valid_low", 0, 64'(resp_valid[0]), 64'd0);
    check("release_cmd_ready", 0, 64'(cmd_ready[0]), 64'd1);
    drain(0);

    // Depth-12 instance: out-of-range address 13/14 never writes and reports an error.
    base = wr_count[1];
    issue(1, OP_WRITE, 4'd13, 32'h1111_2222);
    issue(1, OP_READ, 4'd13, 32'h0);
    issue(1, OP_ADD, 4'd14, 32'd5);
    issue(1, OP_WRITE, 4'd11, 32'h0000_1234);
    issue(1, OP_READ, 4'd11, 32'h0);
    drain(1);
    check("oor_write_pulses", 1, 64'(wr_count[1] - base), 64'd1);

    // Reset in the middle of a FILL, after four writes have landed.
    base = wr_count[0];
    begin
      wr_t w;
      for (int i = 0; i < 16; i++) begin
        w.addr = 4'(i); w.data = 32'hC3C3C3C3;
        exp_wr[0].push_back(w);
      end
    end
    send(0, OP_FILL, 4'h0, 32'hC3C3C3C3);
    n = 0;
    while ((wr_count[0] - base) < 4 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midfill_writes_before_rst", 0, 64'(wr_count[0] - base), 64'd4);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midfill_rst_we", 0, 64'(rf_we_n[0]), 64'd1);
    check("midfill_rst_busy", 0, 64'(busy[0]), 64'd0);
    check("midfill_rst_ready", 0, 64'(cmd_ready[0]), 64'd1);
    exp_wr[0].delete();
    for (int i = 0; i < 4; i++) model[0][i] = 32'hC3C3C3C3;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 16; i++) issue(0, OP_READ, 4'(i), 32'h0);
    drain(0);

    // Randomized traffic on both instances with random response back-pressure.
    for (int k = 0; k < 2; k++) begin
      rr_random[k] = 1'b1;
      for (int t = 0; t < 150; t++) begin
        sel = $urandom_range(0, 19);
        ra  = 4'($urandom_range(0, 15));
        if (sel == 0)      issue(k, OP_FILL, ra, $urandom);
        else if (sel < 7)  issue(k, OP_READ, ra, $urandom);
        else if (sel < 13) issue(k, OP_WRITE, ra, $urandom);
        else               issue(k, OP_ADD, ra, (sel < 16) ? 32'hFFFF_FFFF : $urandom);
      end
      drain(k);
      rr_random[k] = 1'b0;
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
